subtrator_serial_param: RTL and testbench

//   Multi-cycle, digit-serial subtractor: S = A - B - Bin over WIDTH bits, DIGIT bits per clock.

---
 rtl/subtrator_serial_param.sv | 137 +++++++++++++
 tb/tb_subtrator_serial_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/subtrator_serial_param.sv
`default_nettype none
// ============================================================================
// Module   : subtrator_serial_param
// Brief    : Digit-serial subtractor S = A - B - Bin, DIGIT bits per clock.
// Revision : 1.0  initial release
// ============================================================================
module subtrator_serial_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("subtrator_serial_param: WIDTH must be >=2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT:0]   w_dig_diff;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  // Operands shift right so the active digit always sits in the low DIGIT bits;
  // the extra top bit of the digit difference is the borrow out of that digit.
  assign w_dig_diff = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - (DIGIT+1)'(br_q);
  assign w_acc_next = (acc_q >> DIGIT) | (WIDTH'(w_dig_diff[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_last     = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      acc_q   <= '0;
      s_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    acc_d   = acc_q;
    s_d     = s_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        br_d  = w_dig_diff[DIGIT];
        acc_d = w_acc_next;
        cnt_d = cnt_q + CW'(1);
        if (w_last) begin
          // On the final digit the low operand bits hold the original sign bits.
          s_d     = w_acc_next;
          bout_d  = w_dig_diff[DIGIT];
          ovf_d   = (a_q[DIGIT-1] != b_q[DIGIT-1]) && (w_dig_diff[DIGIT-1] != a_q[DIGIT-1]);
          zero_d  = (w_acc_next == '0);
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign s    = s_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_subtrator_serial_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtrator_serial_param
// Brief    : Directed and random checks of the digit-serial subtractor.
// Revision : 1.0  initial release
// ============================================================================
module tb_subtrator_serial_param;

  logic clk;
  logic rst_n;

  // 8-bit instances, DIGIT = 1, 2, 4, 8 (index 0 is the primary DUT)
  logic       start8;
  logic [7:0] a8, b8;
  logic       bin8;
  logic       busy8 [4];
  logic       done8 [4];
  logic [7:0] s8    [4];
  logic       bout8 [4];
  logic       ovf8  [4];
  logic       zero8 [4];

  // 16-bit instance, DIGIT = 4
  logic        start16;
  logic [15:0] a16, b16;
  logic        bin16;
  logic        busy16, done16, bout16, ovf16, zero16;
  logic [15:0] s16;

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_d8
    subtrator_serial_param #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .bin   (bin8),
      .busy  (busy8[gi]),
      .done  (done8[gi]),
      .s     (s8[gi]),
      .bout  (bout8[gi]),
      .ovf   (ovf8[gi]),
      .zero  (zero8[gi])
    );
  end

  subtrator_serial_param #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .bin   (bin16),
    .busy  (busy16),
    .done  (done16),
    .s     (s16),
    .bout  (bout16),
    .ovf   (ovf16),
    .zero  (zero16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one sample after the accepting edge; returns edges until done is seen.
  task automatic wait_done8(output int n, output int busyc);
    n = 0;
    busyc = 0;
    while (!done8[0] && n < 40) begin
      if (busy8[0]) busyc++;
      if (busy8[0] && done8[0]) check("busy_done_excl", 1, 0);
      tick();
      n++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] es, input logic eb, input logic eo, input logic ez,
                     input bit all);
    int n, busyc;
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(n, busyc);
    check({tag, "_lat"}, n, 8);
    check({tag, "_busy"}, busyc, 8);
    for (int i = 0; i < (all ? 4 : 1); i++) begin
      check($sformatf("%s_s_d%0d", tag, 1 << i), s8[i], es);
      check($sformatf("%s_bout_d%0d", tag, 1 << i), bout8[i], eb);
      check($sformatf("%s_ovf_d%0d", tag, 1 << i), ovf8[i], eo);
      check($sformatf("%s_zero_d%0d", tag, 1 << i), zero8[i], ez);
    end
    tick();
    check({tag, "_done_pulse"}, done8[0], 0);
  endtask

  initial begin
    int n, busyc, dcount;
    logic [8:0] ref9;
    logic [7:0] ra, rb;
    logic       rbin, rovf;

    rst_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    tick(); tick();
    check("rst_busy", busy8[0], 0);
    check("rst_done", done8[0], 0);
    check("rst_s", s8[0], 0);
    check("rst_flags", {bout8[0], ovf8[0], zero8[0]}, 0);
    rst_n = 1'b1;
    tick();

    op8("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    op8("t2a", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
    op8("t2b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    op8("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1);
    op8("t3b", 8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    op8("t3c", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1);

    // Start pulse with new operands in RUN cycle 3 must be ignored.
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(n, busyc);
    check("mid_lat", n, 5);
    check("mid_s", s8[0], 8'h02);
    check("mid_bout", bout8[0], 0);
    tick();
    check("mid_not_queued", {busy8[0], done8[0]}, 0);

    // Back-to-back: start held through DONE, operands changed during RUN.
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h20; b8 = 8'h30; bin8 = 1'b1;
    wait_done8(n, busyc);
    check("b2b1_lat", n, 8);
    check("b2b1_s", s8[0], 8'h0F);
    check("b2b1_bout", bout8[0], 0);
    tick();
    start8 = 1'b0;
    check("b2b_no_idle", busy8[0], 1);
    check("b2b_s_held", s8[0], 8'h0F);
    wait_done8(n, busyc);
    check("b2b2_lat", n, 8);
    check("b2b2_s", s8[0], 8'hEF);
    check("b2b2_bout", bout8[0], 1);
    tick();

    // Reset in RUN cycle 3 aborts the operation.
    a8 = 8'h42; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", busy8[0], 0);
    check("abort_done", done8[0], 0);
    check("abort_s", s8[0], 0);
    check("abort_flags", {bout8[0], ovf8[0], zero8[0]}, 0);
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8[0] || busy8[0]) dcount++;
      tick();
    end
    check("abort_no_done", dcount, 0);

    // 16-bit, 4-bit digits: four RUN cycles.
    a16 = 16'h1000; b16 = 16'h0001; bin16 = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    n = 0; busyc = 0;
    while (!done16 && n < 40) begin
      if (busy16) busyc++;
      tick();
      n++;
    end
    check("w16_lat", n, 4);
    check("w16_busy", busyc, 4);
    check("w16_s", s16, 16'h0FFF);
    check("w16_bout", bout16, 0);
    tick();
    a16 = 16'h8000; b16 = 16'h0000; bin16 = 1'b1; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 40) begin
      tick();
      n++;
    end
    check("w16b_lat", n, 4);
    check("w16b_s", s16, 16'h7FFF);
    check("w16b_flags", {bout16, ovf16, zero16}, 3'b010);
    tick();

    // Random operands across all digit sizes of the 8-bit width.
    for (int k = 0; k < 24; k++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      rovf = (ra[7] != rb[7]) && (ref9[7] != ra[7]);
      op8($sformatf("rnd%0d", k), ra, rb, rbin, ref9[7:0], ref9[8], rovf, ref9[7:0] == 8'h00, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
